// File: rtl/bcd_display_driver_pkg.sv
// Shared types and constants for the BCD display driver: FSM encodings,
// digit payload, active-low segment patterns and digit-enable codes.
package bcd_display_driver_pkg;

  localparam int unsigned BIN_W   = 8;
  localparam int unsigned BCD_W   = 12;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;
  localparam int unsigned AN_W    = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIGIT_W-1:0] hund;
    logic [DIGIT_W-1:0] tens;
    logic [DIGIT_W-1:0] units;
  } digits_t;

  // Active-low segments, bit0 = a ... bit6 = g.
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  localparam logic [AN_W-1:0] AN_UNITS = 3'b110;
  localparam logic [AN_W-1:0] AN_TENS  = 3'b101;
  localparam logic [AN_W-1:0] AN_HUND  = 3'b011;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < 3; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_display_driver_seg7.sv
// Active-low 7-segment decoder: 4-bit code plus blank flag to segments.
module seg7_decoder
  import bcd_display_driver_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    if (!blank) begin
      case (code)
        4'd0:    seg_c = SEG_0;
        4'd1:    seg_c = SEG_1;
        4'd2:    seg_c = SEG_2;
        4'd3:    seg_c = SEG_3;
        4'd4:    seg_c = SEG_4;
        4'd5:    seg_c = SEG_5;
        4'd6:    seg_c = SEG_6;
        4'd7:    seg_c = SEG_7;
        4'd8:    seg_c = SEG_8;
        4'd9:    seg_c = SEG_9;
        default: seg_c = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_driver.sv
// Binary-to-BCD converter (double dabble, one bit per cycle) driving a
// three-digit multiplexed active-low 7-segment display.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] y,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_e             state;
  state_e             next_state;
  logic               load_c;
  logic               shift_c;
  logic               commit_c;

  logic [BIN_W-1:0]   bin_q;
  logic [BIN_W-1:0]   cap_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BIN_W-1:0]   last_val;
  digits_t            digits_q;

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   digit_idx;
  logic [DIGIT_W-1:0] sel_code_c;
  logic               sel_blank_c;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (y != last_val) next_state = CONV;
      CONV:    if (bit_cnt == CNT_W'(1)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // FSM control decode
  always_comb begin
    load_c   = 1'b0;
    shift_c  = 1'b0;
    commit_c = 1'b0;
    unique case (state)
      IDLE:    load_c   = (y != last_val);
      CONV:    shift_c  = 1'b1;
      DONE:    commit_c = 1'b1;
      default: ;
    endcase
  end

  // Conversion datapath; cap_q keeps the sampled value since bin_q is shifted out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q    <= '0;
      cap_q    <= '0;
      bcd_q    <= '0;
      bit_cnt  <= '0;
      last_val <= '0;
      digits_q <= '0;
    end else begin
      if (load_c) begin
        bin_q   <= y;
        cap_q   <= y;
        bcd_q   <= '0;
        bit_cnt <= CNT_W'(BIN_W);
      end else if (shift_c) begin
        {bcd_q, bin_q} <= {dabble_adjust(bcd_q), bin_q} << 1;
        bit_cnt        <= bit_cnt - CNT_W'(1);
      end
      if (commit_c) begin
        digits_q <= digits_t'(bcd_q);
        last_val <= cap_q;
      end
    end
  end

  // busy tracks the state being entered, so it is high exactly in CONV/DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
    end
  end

  // Free-running digit scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == IDX_W'(2)) ? '0 : digit_idx + IDX_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Digit select, leading-zero blanking and anode decode
  always_comb begin
    sel_code_c  = digits_q.units;
    sel_blank_c = 1'b0;
    an          = AN_UNITS;
    unique case (digit_idx)
      IDX_W'(1): begin
        sel_code_c  = digits_q.tens;
        sel_blank_c = blank_lz && (digits_q.hund == '0) && (digits_q.tens == '0);
        an          = AN_TENS;
      end
      IDX_W'(2): begin
        sel_code_c  = digits_q.hund;
        sel_blank_c = blank_lz && (digits_q.hund == '0);
        an          = AN_HUND;
      end
      default: ;
    endcase
  end

  seg7_decoder u_seg7 (
    .code  (sel_code_c),
    .blank (sel_blank_c),
    .seg_c (seg)
  );

endmodule

// File: tb/tb_bcd_display_driver.sv
// Self-checking bench for bcd_display_driver: directed corner sequences,
// a vector table and an exhaustive sweep, all through a display scoreboard.
module tb_bcd_display_driver;

  localparam int unsigned SCAN_DIV = 4;
  localparam int          SCAN_CYC = 3 * SCAN_DIV;
  localparam int          SETTLE   = 11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] y = 8'd0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] u;
  } exp_t;

  typedef struct packed {
    logic [7:0] y;
    logic       blz;
    logic [3:0] dh;
    logic [3:0] dt;
    logic [3:0] du;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[10];

  always #5 clk = ~clk;

  bcd_display_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .y        (y),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .busy     (busy)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic exp_t make_exp(input logic [3:0] dh, input logic [3:0] dt,
                                    input logic [3:0] du, input logic blz);
    exp_t e;
    e.h = (blz && dh == 4'd0) ? 7'h7F : ref_seg(dh);
    e.t = (blz && dh == 4'd0 && dt == 4'd0) ? 7'h7F : ref_seg(dt);
    e.u = ref_seg(du);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan(input int n, output logic [6:0] sh, output logic [6:0] st,
                      output logic [6:0] su, output logic [2:0] seen, output logic bad);
    sh = 7'h7F; st = 7'h7F; su = 7'h7F; seen = 3'b000; bad = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      case (an)
        3'b110:  begin su = seg; seen[0] = 1'b1; end
        3'b101:  begin st = seg; seen[1] = 1'b1; end
        3'b011:  begin sh = seg; seen[2] = 1'b1; end
        default: bad = 1'b1;
      endcase
    end
  endtask

  task automatic compare_display(input string name, input logic [6:0] sh, input logic [6:0] st,
                                 input logic [6:0] su, input logic [2:0] seen, input logic bad);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, no expected value", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, " an_valid"}, 32'(bad), 32'(1'b0));
    chk({name, " slots_seen"}, 32'(seen), 32'(3'b111));
    chk({name, " segs"}, 32'({sh, st, su}), 32'({e.h, e.t, e.u}));
  endtask

  task automatic check_display(input string name);
    logic [6:0] sh, st, su;
    logic [2:0] seen;
    logic       bad;
    scan(SCAN_CYC, sh, st, su, seen, bad);
    compare_display(name, sh, st, su, seen, bad);
  endtask

  initial begin
    logic       busy_rec[1:20];
    logic [6:0] sh, st, su;
    logic [2:0] seen;
    logic       bad;

    vecs[0] = '{8'd255, 1'b0, 4'd2, 4'd5, 4'd5};
    vecs[1] = '{8'd7,   1'b1, 4'd0, 4'd0, 4'd7};
    vecs[2] = '{8'd7,   1'b0, 4'd0, 4'd0, 4'd7};
    vecs[3] = '{8'd100, 1'b1, 4'd1, 4'd0, 4'd0};
    vecs[4] = '{8'd40,  1'b1, 4'd0, 4'd4, 4'd0};
    vecs[5] = '{8'd0,   1'b1, 4'd0, 4'd0, 4'd0};
    vecs[6] = '{8'd0,   1'b0, 4'd0, 4'd0, 4'd0};
    vecs[7] = '{8'd209, 1'b1, 4'd2, 4'd0, 4'd9};
    vecs[8] = '{8'd99,  1'b1, 4'd0, 4'd9, 4'd9};
    vecs[9] = '{8'd128, 1'b0, 4'd1, 4'd2, 4'd8};

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("reset seg", 32'(seg), 32'(7'b1000000));
    chk("reset an", 32'(an), 32'(3'b110));
    chk("reset busy", 32'(busy), 32'(1'b0));
    repeat (3) tick();
    @(negedge clk);
    rst_n = 1'b1;

    // Scan rotation from reset: digit advances every SCAN_DIV edges
    for (int k = 1; k <= SCAN_CYC; k++) begin
      logic [2:0] exp_an;
      tick();
      case ((k / SCAN_DIV) % 3)
        0:       exp_an = 3'b110;
        1:       exp_an = 3'b101;
        default: exp_an = 3'b011;
      endcase
      chk($sformatf("rotation an k=%0d", k), 32'(an), 32'(exp_an));
    end

    // Conversion of 255 with busy timing
    y = 8'd255;
    sb_q.push_back(make_exp(4'd2, 4'd5, 4'd5, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("conv255 busy k=%0d", k), 32'(busy), 32'(k <= 9));
    end
    check_display("conv255 display");

    // y changed during conversion: 100 completes, then 37 is picked up
    y = 8'd100;
    sb_q.push_back(make_exp(4'd1, 4'd0, 4'd0, 1'b0));
    sb_q.push_back(make_exp(4'd0, 4'd3, 4'd7, 1'b0));
    sh = 7'h7F; st = 7'h7F; su = 7'h7F; seen = 3'b000; bad = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      busy_rec[k] = busy;
      if (k == 3) y = 8'd37;
      if (k >= 10 && k <= 19) begin
        case (an)
          3'b110:  begin su = seg; seen[0] = 1'b1; end
          3'b101:  begin st = seg; seen[1] = 1'b1; end
          3'b011:  begin sh = seg; seen[2] = 1'b1; end
          default: bad = 1'b1;
        endcase
      end
    end
    for (int k = 1; k <= 20; k++) begin
      chk($sformatf("midchange busy k=%0d", k), 32'(busy_rec[k]),
          32'((k <= 9) || (k >= 11 && k <= 19)));
    end
    compare_display("midchange first", sh, st, su, seen, bad);
    check_display("midchange second");

    // Reset asserted mid-conversion aborts it and clears the digits
    y = 8'd200;
    repeat (3) tick();
    chk("abort busy before reset", 32'(busy), 32'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("async reset seg", 32'(seg), 32'(7'b1000000));
    chk("async reset an", 32'(an), 32'(3'b110));
    chk("async reset busy", 32'(busy), 32'(1'b0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("held reset seg k=%0d", k), 32'(seg), 32'(7'b1000000));
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(make_exp(4'd2, 4'd0, 4'd0, 1'b0));
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("abort restart busy k=%0d", k), 32'(busy), 32'(k <= 9));
    end
    check_display("abort restart display");

    // Vector table, including leading-zero blanking cases
    for (int i = 0; i < 10; i++) begin
      y = vecs[i].y;
      blank_lz = vecs[i].blz;
      sb_q.push_back(make_exp(vecs[i].dh, vecs[i].dt, vecs[i].du, vecs[i].blz));
      repeat (SETTLE) tick();
      chk($sformatf("vec%0d busy idle", i), 32'(busy), 32'(1'b0));
      check_display($sformatf("vec%0d y=%0d blz=%0b", i, vecs[i].y, vecs[i].blz));
    end

    // Exhaustive sweep against an arithmetic model
    blank_lz = 1'b0;
    for (int v = 0; v < 256; v++) begin
      y = 8'(v);
      sb_q.push_back(make_exp(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), 1'b0));
      repeat (SETTLE) tick();
      check_display($sformatf("sweep y=%0d", v));
    end

    chk("scoreboard drained", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_display_driver.md
BCD_DISPLAY_DRIVER -- requirements
Module: bcd_display_driver

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000, setting the number of clk cycles each digit is driven (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have port y, input, 8, the unsigned binary counter value to display (0..255).
REQ-005 The block SHALL have port blank_lz, input, 1, which enables leading-zero blanking when 1.
REQ-006 The block SHALL have port seg, output, 7, active-low segments, bit0=a through bit6=g.
REQ-007 The block SHALL have port an, output, 3, active-low one-hot digit enables: an[0]=units, an[1]=tens, an[2]=hundreds.
REQ-008 The block SHALL have port busy, output, 1, high while a conversion is in progress.

Function
REQ-009 The conversion FSM SHALL have three states: IDLE, CONV and DONE.
REQ-010 In IDLE, if y != last_val, the FSM SHALL capture y into the shift register, clear the 12-bit BCD register, load bit_cnt=8 and go to CONV; otherwise it SHALL stay in IDLE.
REQ-011 In CONV, each cycle SHALL add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1 and decrement bit_cnt; after the 8th shift the FSM SHALL go to DONE.
REQ-012 In DONE, the FSM SHALL copy the BCD nibbles into the digit registers (hund, tens, units), set last_val to the captured value and return to IDLE.
REQ-013 Latency SHALL be exactly 10 cycles: y sampled at edge N; digit registers updated at edge N+9; the new digits are visible on seg from cycle N+10.
REQ-014 busy SHALL be 1 in CONV and DONE and 0 in IDLE.
REQ-015 Changes on y during CONV or DONE SHALL be ignored; the in-flight conversion SHALL complete, and the new value SHALL be picked up by the IDLE compare on the following cycle.
REQ-016 The scan counter SHALL count 0..SCAN_DIV-1 and wrap to 0; on wrap, digit_idx SHALL advance 0->1->2->0.
REQ-017 an SHALL be the active-low one-hot decode of digit_idx: 3'b110, 3'b101, 3'b011.
REQ-018 seg SHALL be the active-low 7-segment pattern of the selected digit register; digits 0..9 SHALL use standard patterns, and codes 10..15 SHALL produce all-off (7'b1111111).
REQ-019 When blank_lz=1, the hundreds digit SHALL be blanked if hund=0, and the tens digit SHALL be blanked if hund=0 and tens=0; the units digit SHALL never be blanked.
REQ-020 seg and an SHALL be combinational decodes of registered state only, with no path from y.
REQ-021 Scanning SHALL run continuously, independent of the FSM state.

Reset
REQ-022 rst_n=0 SHALL asynchronously set state=IDLE, last_val=0, hund/tens/units=0, shift/BCD registers=0, bit_cnt=0, scan counter=0 and digit_idx=0.
REQ-023 During and immediately after reset, the outputs SHALL be seg=7'b1000000, an=3'b110 and busy=0.
REQ-024 Reset asserted mid-conversion SHALL abort it; the digit registers SHALL read 0, and an input y != 0 SHALL restart conversion from IDLE after release.

Structure
REQ-025 A shared package SHALL hold the FSM state encodings (IDLE=2'd0, CONV=2'd1, DONE=2'd2), the 7-segment pattern constants for 0..9 and blank, and the digit-enable constants.
REQ-026 The block SHALL instantiate one sub-module, seg7_decoder (4-bit code + blank flag -> 7-bit active-low segments), as the only segment-decode logic.

Verification
REQ-027 Reset check: assert rst_n=0 mid-run -> seg=7'b1000000, an=3'b110 and busy=0 immediately, without waiting for a clock edge.
REQ-028 Conversion check (SCAN_DIV=4): from reset apply y=8'd255 -> busy rises 1 cycle later and stays high 9 cycles; digits read 2,5,5 at cycle 10; an cycles 110,101,011 every 4 clk.
REQ-029 Blanking check: y=8'd7 with blank_lz=1 -> hundreds and tens scan slots show seg=7'b1111111 and units shows 7'b1111000; with blank_lz=0 -> the same slots show 7'b1000000, 7'b1000000 and 7'b1111000.
REQ-030 Mid-conversion change: y=8'd100, then y=8'd37 three cycles later -> digits read 1,0,0, then 0,3,7 after 11 further cycles; busy drops for exactly 1 cycle between the two conversions.
REQ-031 Reset abort: y=8'd200 with rst_n pulsed low during CONV -> digits stay 0,0,0 during reset; after release, busy reasserts and digits read 2,0,0.
REQ-032 Exhaustive sweep: all y in 0..255, each held until busy falls -> the decoded digits equal y/100, (y/10)%10 and y%10 for every value.
